gerador_acionamento: RTL and testbench

GERADOR_ACIONAMENTO -- requirements
Module: gerador_acionamento

---
 rtl/gerador_acionamento_if.sv | 23 ++
 rtl/gerador_acionamento.sv | 178 +++++++++++++++++
 tb/tb_gerador_acionamento.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/gerador_acionamento_if.sv
// Command and emulated-signal bundle between a test controller (master)
// and the button/presence-sensor stimulus generator (slave).
interface gerador_acionamento_if;
    logic        cmd_valid;
    logic [1:0]  cmd_op;
    logic [15:0] cmd_arg;
    logic        cmd_ready;
    logic        abort;
    logic        push_button;
    logic        infravermelho;
    logic        busy;
    logic        done;

    modport master (
        output cmd_valid, cmd_op, cmd_arg, abort,
        input  cmd_ready, push_button, infravermelho, busy, done
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_arg, abort,
        output cmd_ready, push_button, infravermelho, busy, done
    );
endinterface

// File: rtl/gerador_acionamento.sv
// Emulates a bouncing push button (short/long press) and a presence sensor
// pulse for exercising a debounce controller; all durations count tick_1ms.
module gerador_acionamento #(
    parameter int DEBOUNCE_P        = 300,
    parameter int SWITCH_MODE_MIN_T = 5000,
    parameter int BOUNCE_N          = 4,
    parameter int BOUNCE_T          = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    tick_1ms,
    gerador_acionamento_if.slave    bus
);

    localparam logic [15:0] BOUNCE_LEN = 16'(2 * BOUNCE_N * BOUNCE_T);
    localparam logic [15:0] SHORT_LEN  = 16'(2 * DEBOUNCE_P);
    localparam logic [15:0] LONG_LEN   = 16'(SWITCH_MODE_MIN_T + DEBOUNCE_P);
    localparam logic [15:0] GAP_LEN    = 16'(DEBOUNCE_P);
    localparam logic [15:0] BT_LAST    = 16'(BOUNCE_T - 1);

    if (2 * DEBOUNCE_P >= SWITCH_MODE_MIN_T) begin : g_chk_press
        $error("2*DEBOUNCE_P must be less than SWITCH_MODE_MIN_T");
    end
    if (SWITCH_MODE_MIN_T + DEBOUNCE_P > 65535) begin : g_chk_long
        $error("SWITCH_MODE_MIN_T+DEBOUNCE_P exceeds the 16-bit phase counter");
    end
    if (2 * BOUNCE_N * BOUNCE_T > 65535) begin : g_chk_bounce
        $error("2*BOUNCE_N*BOUNCE_T exceeds the 16-bit phase counter");
    end
    if (BOUNCE_T < 1) begin : g_chk_bt
        $error("BOUNCE_T must be at least 1");
    end

    typedef enum logic [2:0] {
        IDLE, PR_BOUNCE, PR_HOLD, RL_BOUNCE, RL_GAP, PRES_ON, DONE
    } state_t;

    // Bounce phases vanish entirely when BOUNCE_N is zero.
    function automatic state_t press_entry();
        return (BOUNCE_N > 0) ? PR_BOUNCE : PR_HOLD;
    endfunction

    function automatic state_t next_phase(input state_t s);
        case (s)
            PR_BOUNCE: return PR_HOLD;
            PR_HOLD:   return (BOUNCE_N > 0) ? RL_BOUNCE : RL_GAP;
            RL_BOUNCE: return RL_GAP;
            default:   return DONE;
        endcase
    endfunction

    state_t      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [15:0] bt_q, bt_d;
    logic        pb_q, pb_d;
    logic        ir_q, ir_d;
    logic        done_q, done_d;
    logic        busy_q, busy_d;
    logic        ready_q, ready_d;
    logic [1:0]  op_q, op_d;
    logic [15:0] arg_q, arg_d;

    logic [15:0] phase_len;
    logic        go;
    state_t      nxt;

    always_comb begin
        phase_len = 16'd1;
        case (state_q)
            PR_BOUNCE, RL_BOUNCE: phase_len = BOUNCE_LEN;
            PR_HOLD:              phase_len = op_q[0] ? LONG_LEN : SHORT_LEN;
            RL_GAP:               phase_len = GAP_LEN;
            PRES_ON:              phase_len = (arg_q == 16'd0) ? 16'd1 : arg_q;
            default:              phase_len = 16'd1;
        endcase
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bt_d    = bt_q;
        pb_d    = pb_q;
        ir_d    = ir_q;
        done_d  = 1'b0;
        busy_d  = busy_q;
        ready_d = ready_q;
        op_d    = op_q;
        arg_d   = arg_q;
        go      = 1'b0;
        nxt     = state_q;

        case (state_q)
            IDLE: begin
                // A coincident abort suppresses acceptance.
                if (bus.cmd_valid && !bus.abort) begin
                    go    = 1'b1;
                    op_d  = bus.cmd_op;
                    arg_d = bus.cmd_arg;
                    case (bus.cmd_op)
                        2'b10:   nxt = PRES_ON;
                        2'b11:   nxt = DONE;
                        default: nxt = press_entry();
                    endcase
                end
            end
            DONE: begin
                go  = 1'b1;
                nxt = IDLE;
            end
            default: begin
                if (tick_1ms) begin
                    if (cnt_q == phase_len - 16'd1) begin
                        go  = 1'b1;
                        nxt = next_phase(state_q);
                    end else begin
                        cnt_d = cnt_q + 16'd1;
                        if (state_q == PR_BOUNCE || state_q == RL_BOUNCE) begin
                            if (bt_q == BT_LAST) begin
                                bt_d = 16'd0;
                                pb_d = ~pb_q;
                            end else begin
                                bt_d = bt_q + 16'd1;
                            end
                        end
                    end
                end
            end
        endcase

        if (state_q != IDLE && bus.abort) begin
            go  = 1'b1;
            nxt = IDLE;
        end

        // Every state entry restarts the counters and loads the entry outputs.
        if (go) begin
            state_d = nxt;
            cnt_d   = 16'd0;
            bt_d    = 16'd0;
            pb_d    = (nxt == PR_BOUNCE) || (nxt == PR_HOLD);
            ir_d    = (nxt == PRES_ON);
            done_d  = (nxt == DONE);
            busy_d  = (nxt != IDLE);
            ready_d = (nxt == IDLE);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= 16'd0;
            bt_q    <= 16'd0;
            pb_q    <= 1'b0;
            ir_q    <= 1'b0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
            ready_q <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bt_q    <= bt_d;
            pb_q    <= pb_d;
            ir_q    <= ir_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
            ready_q <= ready_d;
        end
        op_q  <= op_d;
        arg_q <= arg_d;
    end

    assign bus.push_button   = pb_q;
    assign bus.infravermelho = ir_q;
    assign bus.done          = done_q;
    assign bus.busy          = busy_q;
    assign bus.cmd_ready     = ready_q;

endmodule

// File: tb/tb_gerador_acionamento.sv
// Directed bench for gerador_acionamento with small timing parameters;
// cycle 1 is the accept cycle, outputs are sampled 1 ns after each edge.
module tb_gerador_acionamento;

    localparam int DP = 3;
    localparam int SW = 10;
    localparam int BN = 2;
    localparam int BT = 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic tick_1ms = 1'b0;
    int   tick_period = 1;
    int   tick_ctr = 0;

    int tests = 0;
    int fails = 0;

    gerador_acionamento_if bus();

    gerador_acionamento #(
        .DEBOUNCE_P(DP), .SWITCH_MODE_MIN_T(SW), .BOUNCE_N(BN), .BOUNCE_T(BT)
    ) dut (
        .clk(clk), .rst(rst), .tick_1ms(tick_1ms), .bus(bus)
    );

    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        #1;
        tick_ctr++;
        tick_1ms = ((tick_ctr % tick_period) == 0);
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    typedef struct {
        logic [1:0]  op;
        logic [15:0] arg;
        int          done_cyc;
        logic [63:0] pb_trace;
        logic [63:0] ir_trace;
    } vec_t;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [4:0] status();
        return {bus.push_button, bus.infravermelho, bus.busy, bus.done, bus.cmd_ready};
    endfunction

    // Issues one command in the current (idle) cycle and traces it to done.
    task automatic run_cmd(input logic [1:0] op, input logic [15:0] arg,
                           output int done_cyc, output logic [63:0] pbt,
                           output logic [63:0] irt, output logic busy2,
                           output logic ready_after);
        pbt = '0; irt = '0; done_cyc = -1; busy2 = 1'b0; ready_after = 1'b0;
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = op;
        bus.cmd_arg   = arg;
        step();
        bus.cmd_valid = 1'b0;
        for (int cyc = 2; cyc < 200; cyc++) begin
            if (cyc == 2) busy2 = bus.busy;
            if (cyc < 64) begin
                pbt[cyc] = bus.push_button;
                irt[cyc] = bus.infravermelho;
            end
            if (bus.done) begin
                done_cyc = cyc;
                step();
                ready_after = bus.cmd_ready;
                break;
            end
            step();
        end
        if (done_cyc < 0) begin
            rst = 1'b1;
            step();
            rst = 1'b0;
        end
    endtask

    initial begin
        vec_t        vecs[6];
        int          dc;
        logic [63:0] pbt, irt;
        logic        b2, rdy;
        logic        seen;
        int          n;

        vecs[0] = '{2'b00, 16'd9, 19, 64'hAFD4,   64'h0};
        vecs[1] = '{2'b01, 16'd0, 26, 64'h57FFD4, 64'h0};
        vecs[2] = '{2'b10, 16'd5, 7,  64'h0,      64'h7C};
        vecs[3] = '{2'b10, 16'd0, 3,  64'h0,      64'h4};
        vecs[4] = '{2'b11, 16'd0, 2,  64'h0,      64'h0};
        vecs[5] = '{2'b10, 16'd1, 3,  64'h0,      64'h4};

        bus.cmd_valid = 1'b0;
        bus.cmd_op    = 2'b00;
        bus.cmd_arg   = 16'd0;
        bus.abort     = 1'b0;
        rst = 1'b1;
        repeat (3) step();
        check("reset_state", 64'(status()), 64'b00001);
        rst = 1'b0;
        step();

        for (int i = 0; i < 6; i++) begin
            run_cmd(vecs[i].op, vecs[i].arg, dc, pbt, irt, b2, rdy);
            check($sformatf("v%0d_done_cycle", i), 64'(dc), 64'(vecs[i].done_cyc));
            check($sformatf("v%0d_pb_trace", i), pbt, vecs[i].pb_trace);
            check($sformatf("v%0d_ir_trace", i), irt, vecs[i].ir_trace);
            check($sformatf("v%0d_busy_c2", i), 64'(b2), 64'd1);
            check($sformatf("v%0d_ready_after", i), 64'(rdy), 64'd1);
        end

        // Abort in the first stable-high cycle of a short press.
        bus.cmd_valid = 1'b1; bus.cmd_op = 2'b00; bus.cmd_arg = 16'd0;
        step();
        bus.cmd_valid = 1'b0;
        repeat (4) step();
        check("abort_pre_hold_pb", 64'(bus.push_button), 64'd1);
        bus.abort = 1'b1;
        step();
        bus.abort = 1'b0;
        check("abort_state", 64'(status()), 64'b00001);
        bus.cmd_valid = 1'b1; bus.cmd_op = 2'b11;
        step();
        bus.cmd_valid = 1'b0;
        check("abort_reaccept", 64'({bus.busy, bus.done}), 64'b11);
        step();

        // Abort coinciding with a request while idle blocks acceptance.
        bus.abort = 1'b1; bus.cmd_valid = 1'b1; bus.cmd_op = 2'b10; bus.cmd_arg = 16'd3;
        step();
        bus.abort = 1'b0; bus.cmd_valid = 1'b0;
        check("abort_accept_clash", 64'({bus.busy, bus.infravermelho, bus.cmd_ready}), 64'b001);
        step();

        // Requests while busy are dropped.
        bus.cmd_valid = 1'b1; bus.cmd_op = 2'b10; bus.cmd_arg = 16'd4;
        step();
        bus.cmd_valid = 1'b0;
        step();
        bus.cmd_valid = 1'b1; bus.cmd_op = 2'b00;
        step();
        bus.cmd_valid = 1'b0;
        dc = -1; seen = 1'b0;
        for (int cyc = 4; cyc < 60; cyc++) begin
            seen |= bus.push_button;
            if (bus.done) begin dc = cyc; break; end
            step();
        end
        check("busy_ignore_done", 64'(dc), 64'd6);
        check("busy_ignore_pb", 64'(seen), 64'd0);
        seen = 1'b0;
        repeat (6) begin
            step();
            seen |= bus.busy | bus.push_button;
        end
        check("busy_ignore_idle", 64'(seen), 64'd0);

        // Slow timebase: one tick every fourth cycle.
        tick_period = 4;
        step();
        run_cmd(2'b10, 16'd2, dc, pbt, irt, b2, rdy);
        n = $countones(irt);
        tests++;
        if (dc < 0 || n < 5 || n > 11) begin
            fails++;
            $display("FAIL tick_gate_ir: got %0d cycles (done %0d) expected 5..11", n, dc);
        end
        tick_period = 1;
        step();

        // Reset during the stable-high phase.
        bus.cmd_valid = 1'b1; bus.cmd_op = 2'b00;
        step();
        bus.cmd_valid = 1'b0;
        repeat (5) step();
        check("rst_pre_hold_pb", 64'(bus.push_button), 64'd1);
        rst = 1'b1;
        step();
        check("rst_mid_hold", 64'(status()), 64'b00001);
        rst = 1'b0;
        seen = 1'b0;
        repeat (25) begin
            step();
            seen |= bus.done | bus.busy;
        end
        check("rst_no_done", 64'(seen), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
